// File: rtl/attributes_inverse_pkg.sv
// Shared types, defaults and the forward reference model for the
// attributes datapath inverse.
package attr_pkg;

  localparam int DEF_NBITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Forward AttributesTest datapath: (a+b)-(a-b)+a*b truncated to nbits.
  // Arithmetic is done at 32 bits; truncation afterwards gives the same
  // result as nbits-wide modular arithmetic for nbits <= 32.
  function automatic logic [31:0] fwd_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          nbits);
    logic [31:0] r;
    r = (a + b) - (a - b) + a * b;
    if (nbits >= 32) return r;
    return r & ((32'd1 << nbits) - 32'd1);
  endfunction

endpackage

// File: rtl/attributes_inverse_if.sv
// Request/response handshake bundle for the attributes inverse block.
interface attributes_inverse_if #(parameter int NBITS = attr_pkg::DEF_NBITS);
  logic             IN_VALID;
  logic             IN_READY;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] XOUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [NBITS-1:0] B;
  logic             FOUND;

  // Request source / result consumer side
  modport master (
    output IN_VALID, A, XOUT, OUT_READY,
    input  IN_READY, OUT_VALID, B, FOUND
  );

  // Inverse block side
  modport slave (
    input  IN_VALID, A, XOUT, OUT_READY,
    output IN_READY, OUT_VALID, B, FOUND
  );
endinterface

// File: rtl/attributes_inverse_step_acc.sv
// Candidate/accumulator pair: acc tracks cand*step mod 2^NBITS using adds
// only, so the search needs no multiplier.
module attr_step_acc
  import attr_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,      // load step/target, restart at cand=0
  input  logic             advance,   // move to the next candidate
  input  logic [NBITS-1:0] step_in,
  input  logic [NBITS-1:0] target_in,
  output logic [NBITS-1:0] cand,
  output logic             last,      // cand is the final candidate
  output logic             match      // acc equals target
);

  logic [NBITS-1:0] cand_q, cand_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] step_q, step_d;
  logic [NBITS-1:0] target_q, target_d;

  // Next-state: init wins over advance; both wrap modulo 2^NBITS
  always_comb begin
    cand_d   = cand_q;
    acc_d    = acc_q;
    step_d   = step_q;
    target_d = target_q;
    if (init) begin
      cand_d   = '0;
      acc_d    = '0;
      step_d   = step_in;
      target_d = target_in;
    end else if (advance) begin
      cand_d = cand_q + 1'b1;
      acc_d  = acc_q + step_q;
    end
  end

  // Register the pair plus the latched operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      target_q <= '0;
    end else begin
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      target_q <= target_d;
    end
  end

  assign cand  = cand_q;
  assign last  = &cand_q;
  assign match = (acc_q == target_q);

endmodule

// File: rtl/attributes_inverse.sv
// Sequential inverse of XOUT = B*(A+2) mod 2^NBITS: walks B = 0,1,2...
// one per cycle and reports the smallest match, or FOUND=0 on exhaustion.
module attributes_inverse
  import attr_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  attributes_inverse_if.slave  bus
);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [NBITS-1:0] b_q, b_d;
  logic             found_q, found_d;

  logic             sa_init;
  logic             sa_advance;
  logic [NBITS-1:0] sa_cand;
  logic             sa_last;
  logic             sa_match;

  attr_step_acc #(.NBITS(NBITS)) u_step_acc (
    .clk       (CLK),
    .rst_n     (RST_N),
    .init      (sa_init),
    .advance   (sa_advance),
    .step_in   (bus.A + NBITS'(2)),  // wrap of A+2 is intended
    .target_in (bus.XOUT),
    .cand      (sa_cand),
    .last      (sa_last),
    .match     (sa_match)
  );

  // FSM and handshake next-state; match is checked before exhaustion so
  // a solution at the last candidate is still reported
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    b_d         = b_q;
    found_d     = found_q;
    sa_init     = 1'b0;
    sa_advance  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.IN_VALID && in_ready_q) begin
          sa_init    = 1'b1;
          in_ready_d = 1'b0;
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        if (sa_match) begin
          b_d         = sa_cand;
          found_d     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (sa_last) begin
          b_d         = '0;
          found_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          sa_advance = 1'b1;
        end
      end
      DONE: begin
        // No overlap: the next request is taken only from IDLE
        if (out_valid_q && bus.OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      b_q         <= '0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      b_q         <= b_d;
      found_q     <= found_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.B         = b_q;
  assign bus.FOUND     = found_q;

endmodule
